// File: rtl/user_interface_ctrl.sv
// Phone front-panel controller: tracks call state and menu item, turns button edges and
// application-layer event codes into one-cycle commands, and describes the text to display.
module user_interface_ctrl #(
  parameter int unsigned VOL_INIT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s7,
  input  logic         s6,
  input  logic         s5,
  input  logic         s4,
  input  logic         s3,
  input  logic         s2,
  input  logic         s1,
  input  logic         s0,
  input  logic         b3,
  input  logic         b2,
  input  logic         b1,
  input  logic         b0,
  input  logic         enter,
  input  logic         up,
  input  logic         down,
  input  logic         left,
  input  logic         right,
  input  logic [2:0]   inc_command,
  input  logic         init,
  output logic         ready,
  output logic [2:0]   command,
  output logic [7:0]   phn_num,
  output logic [15:0]  dout,
  output logic [15:0]  din,
  output logic [2:0]   current_state,
  output logic [5:0]   current_menu_item,
  output logic [7:0]   address,
  output logic [7:0]   inc_address,
  output logic [4:0]   headphone_volume,
  output logic         voicemail_command,
  output logic         voicemail_status,
  output logic         disp_control,
  output logic [127:0] string_data,
  output logic [11:0]  txt_addr,
  output logic [11:0]  txt_length,
  output logic         txt_start,
  output logic [7:0]   ascii_out,
  output logic         ascii_out_ready,
  output logic [15:0]  audio_in_data,
  output logic [15:0]  audio_out_data,
  output logic         done
);

  typedef enum logic [2:0] {
    ST_INIT     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_OUTGOING = 3'd2,
    ST_INCOMING = 3'd3,
    ST_BUSY     = 3'd4,
    ST_ENDING   = 3'd5
  } state_e;

  typedef enum logic [5:0] {
    IT_WELCOME        = 6'd0,
    IT_DATE_TIME      = 6'd1,
    IT_CALL_NUMBER    = 6'd2,
    IT_VOLUME         = 6'd3,
    IT_DIALING        = 6'd4,
    IT_OUT_WAIT       = 6'd5,
    IT_INC_CALLER_ID  = 6'd6,
    IT_INC_ACCEPT     = 6'd7,
    IT_INC_REJECT     = 6'd8,
    IT_BUSY_CALLER_ID = 6'd9,
    IT_BUSY_END       = 6'd10,
    IT_END_WAIT       = 6'd11
  } item_e;

  localparam logic [2:0] CMD_DIAL   = 3'd1;
  localparam logic [2:0] CMD_ACCEPT = 3'd2;
  localparam logic [2:0] CMD_REJECT = 3'd3;
  localparam logic [2:0] CMD_END    = 3'd4;

  localparam logic [2:0] EVT_CONNECTED = 3'd1;
  localparam logic [2:0] EVT_INCOMING  = 3'd5;
  localparam logic [2:0] EVT_ENDED     = 3'd6;

  state_e     state_q;
  item_e      item_q;
  item_e      item_prev_q;
  logic [2:0] cmd_q;
  logic [7:0] phn_q;
  logic       ardy_q;
  logic [4:0] vol_q;
  logic       vm_q;
  logic [7:0] btn_q;
  logic [2:0] inc_q;

  logic [7:0] sw;
  logic [7:0] btn_now;
  logic [7:0] btn_rise;
  logic       enter_re, up_re, down_re, left_re, right_re, b3_re, b1_re, b0_re;
  logic       evt_new;
  logic       unused_b2;

  assign unused_b2 = b2;
  assign sw        = {s7, s6, s5, s4, s3, s2, s1, s0};
  assign btn_now   = {enter, up, down, left, right, b3, b1, b0};
  assign btn_rise  = btn_now & ~btn_q;
  assign {enter_re, up_re, down_re, left_re, right_re, b3_re, b1_re, b0_re} = btn_rise;
  assign evt_new   = (inc_command != inc_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q       <= '0;
      inc_q       <= '0;
      item_prev_q <= IT_WELCOME;
    end else begin
      // NOTE: non-blocking so every edge detector compares against last cycle's value.
      btn_q       <= btn_now;
      inc_q       <= inc_command;
      item_prev_q <= item_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vol_q <= 5'(VOL_INIT);
      vm_q  <= 1'b0;
    end else begin
      vm_q <= b3_re && (state_q == ST_IDLE);
      if (b1_re && vol_q != 5'd31)
        vol_q <= vol_q + 5'd1;
      else if (b0_re && vol_q != 5'd0)
        vol_q <= vol_q - 5'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_INIT;
      item_q  <= IT_WELCOME;
      cmd_q   <= '0;
      phn_q   <= '0;
      ardy_q  <= 1'b0;
    end else begin
      // NOTE: pulse outputs default to 0 each cycle so any set below lasts exactly one clock.
      cmd_q  <= '0;
      ardy_q <= 1'b0;
      if (init) begin
        state_q <= ST_INIT;
        item_q  <= IT_WELCOME;
      end else if (state_q > ST_ENDING || item_q > IT_END_WAIT) begin
        state_q <= ST_IDLE;
        item_q  <= IT_DATE_TIME;
      end else if (evt_new && inc_command == EVT_ENDED &&
                   state_q inside {ST_OUTGOING, ST_INCOMING, ST_BUSY, ST_ENDING}) begin
        state_q <= ST_IDLE;
        item_q  <= IT_DATE_TIME;
      end else if (evt_new && inc_command == EVT_INCOMING && state_q == ST_IDLE) begin
        state_q <= ST_INCOMING;
        item_q  <= IT_INC_CALLER_ID;
      end else if (evt_new && inc_command == EVT_CONNECTED && state_q == ST_OUTGOING) begin
        state_q <= ST_BUSY;
        item_q  <= IT_BUSY_CALLER_ID;
      end else begin
        case (state_q)
          ST_INIT: begin
            if (enter_re) begin
              state_q <= ST_IDLE;
              item_q  <= IT_WELCOME;
            end
          end
          ST_IDLE: begin
            case (item_q)
              IT_WELCOME, IT_DATE_TIME: if (right_re) item_q <= IT_CALL_NUMBER;
              IT_CALL_NUMBER: begin
                if (enter_re)            item_q <= IT_DIALING;
                else if (left_re)        item_q <= IT_DATE_TIME;
                else if (up_re || down_re) item_q <= IT_VOLUME;
              end
              IT_VOLUME: begin
                if (left_re)             item_q <= IT_DATE_TIME;
                else if (up_re || down_re) item_q <= IT_CALL_NUMBER;
              end
              IT_DIALING: begin
                if (enter_re) begin
                  phn_q   <= sw;
                  ardy_q  <= (sw != phn_q);
                  cmd_q   <= CMD_DIAL;
                  state_q <= ST_OUTGOING;
                  item_q  <= IT_OUT_WAIT;
                end else if (left_re) begin
                  item_q <= IT_CALL_NUMBER;
                end
              end
              default: ;
            endcase
          end
          ST_OUTGOING: begin
            if (left_re) begin
              cmd_q   <= CMD_END;
              state_q <= ST_IDLE;
              item_q  <= IT_DATE_TIME;
            end
          end
          ST_INCOMING: begin
            if (enter_re && item_q == IT_INC_ACCEPT) begin
              cmd_q   <= CMD_ACCEPT;
              state_q <= ST_BUSY;
              item_q  <= IT_BUSY_CALLER_ID;
            end else if (enter_re && item_q == IT_INC_REJECT) begin
              cmd_q   <= CMD_REJECT;
              state_q <= ST_IDLE;
              item_q  <= IT_DATE_TIME;
            end else if (down_re) begin
              case (item_q)
                IT_INC_CALLER_ID: item_q <= IT_INC_ACCEPT;
                IT_INC_ACCEPT:    item_q <= IT_INC_REJECT;
                default:          item_q <= IT_INC_CALLER_ID;
              endcase
            end else if (up_re) begin
              case (item_q)
                IT_INC_CALLER_ID: item_q <= IT_INC_REJECT;
                IT_INC_REJECT:    item_q <= IT_INC_ACCEPT;
                default:          item_q <= IT_INC_CALLER_ID;
              endcase
            end
          end
          ST_BUSY: begin
            if (enter_re && item_q == IT_BUSY_END) begin
              cmd_q   <= CMD_END;
              state_q <= ST_ENDING;
              item_q  <= IT_END_WAIT;
            end else if (up_re || down_re) begin
              item_q <= (item_q == IT_BUSY_END) ? IT_BUSY_CALLER_ID : IT_BUSY_END;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Labels are left-justified and space padded to a fixed 16-character field.
  always_comb begin
    // NOTE: default first so every path assigns string_data and no latch is inferred.
    string_data = {16{8'h2d}};
    case (item_q)
      IT_WELCOME:        string_data = {"WELCOME",        {9{8'h20}}};
      IT_DATE_TIME:      string_data = {"DATE_TIME",      {7{8'h20}}};
      IT_CALL_NUMBER:    string_data = {"CALL_NUMBER",    {5{8'h20}}};
      IT_VOLUME:         string_data = {"VOLUME",         {10{8'h20}}};
      IT_DIALING:        string_data = {"DIALING",        {9{8'h20}}};
      IT_OUT_WAIT:       string_data = {"OUT_WAIT",       {8{8'h20}}};
      IT_INC_CALLER_ID:  string_data = {"INC_CALLER_ID",  {3{8'h20}}};
      IT_INC_ACCEPT:     string_data = {"INC_ACCEPT",     {6{8'h20}}};
      IT_INC_REJECT:     string_data = {"INC_REJECT",     {6{8'h20}}};
      IT_BUSY_CALLER_ID: string_data = {"BUSY_CALLER_ID", {2{8'h20}}};
      IT_BUSY_END:       string_data = {"BUSY_END",       {8{8'h20}}};
      IT_END_WAIT:       string_data = {"END_WAIT",       {8{8'h20}}};
      default: ;
    endcase
  end

  assign ready             = (state_q != ST_INIT);
  assign disp_control      = ready;
  assign voicemail_status  = (state_q == ST_IDLE);
  assign voicemail_command = vm_q;
  assign command           = cmd_q;
  assign done              = (cmd_q != 3'd0);
  assign phn_num           = phn_q;
  assign dout              = {8'h00, phn_q};
  assign din               = '0;
  assign current_state     = state_q;
  assign current_menu_item = item_q;
  assign address           = {2'b00, item_q};
  assign inc_address       = {5'b00000, inc_command};
  assign headphone_volume  = vol_q;
  assign txt_addr          = {2'b00, item_q, 4'b0000};
  assign txt_length        = 12'd16;
  assign txt_start         = (item_q != item_prev_q);
  assign ascii_out         = (phn_q[3:0] < 4'd10) ? (8'h30 + {4'h0, phn_q[3:0]})
                                                  : (8'h37 + {4'h0, phn_q[3:0]});
  assign ascii_out_ready   = ardy_q;
  assign audio_in_data     = '0;
  assign audio_out_data    = '0;

endmodule

// File: tb/tb_user_interface_ctrl.sv
// Bench for user_interface_ctrl: directed walk through a call, then random button/event
// traffic compared against a behavioural phone model.
module tb_user_interface_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] sw = '0;
  logic b3 = 0, b2 = 0, b1 = 0, b0 = 0;
  logic enter = 0, up = 0, down = 0, left = 0, right = 0;
  logic [2:0] inc = '0;
  logic init = 0;

  logic         ready, voicemail_command, voicemail_status, disp_control, txt_start;
  logic         ascii_out_ready, done;
  logic [2:0]   command, current_state;
  logic [7:0]   phn_num, address, inc_address, ascii_out;
  logic [15:0]  dout, din, audio_in_data, audio_out_data;
  logic [5:0]   current_menu_item;
  logic [4:0]   headphone_volume;
  logic [127:0] string_data;
  logic [11:0]  txt_addr, txt_length;

  user_interface_ctrl #(.VOL_INIT(16)) dut (
    .clk(clk), .reset(reset),
    .s7(sw[7]), .s6(sw[6]), .s5(sw[5]), .s4(sw[4]),
    .s3(sw[3]), .s2(sw[2]), .s1(sw[1]), .s0(sw[0]),
    .b3(b3), .b2(b2), .b1(b1), .b0(b0),
    .enter(enter), .up(up), .down(down), .left(left), .right(right),
    .inc_command(inc), .init(init),
    .ready(ready), .command(command), .phn_num(phn_num), .dout(dout), .din(din),
    .current_state(current_state), .current_menu_item(current_menu_item),
    .address(address), .inc_address(inc_address), .headphone_volume(headphone_volume),
    .voicemail_command(voicemail_command), .voicemail_status(voicemail_status),
    .disp_control(disp_control), .string_data(string_data),
    .txt_addr(txt_addr), .txt_length(txt_length), .txt_start(txt_start),
    .ascii_out(ascii_out), .ascii_out_ready(ascii_out_ready),
    .audio_in_data(audio_in_data), .audio_out_data(audio_out_data), .done(done)
  );

  always #5 clk = ~clk;

  typedef enum {K_ENTER, K_UP, K_DOWN, K_LEFT, K_RIGHT, K_B3, K_B1, K_B0, K_EVT, K_SW, K_INIT} kind_e;

  localparam int S_INIT = 0, S_IDLE = 1, S_OUT = 2, S_INC = 3, S_BUSY = 4, S_END = 5;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the phone as seen from the panel.
  int       m_state, m_item, m_vol, m_prev_inc;
  logic [7:0] m_phn;
  int       e_cmd;
  bit       e_vm, e_ardy, e_txt;

  string labels [12] = '{"WELCOME", "DATE_TIME", "CALL_NUMBER", "VOLUME", "DIALING", "OUT_WAIT",
                         "INC_CALLER_ID", "INC_ACCEPT", "INC_REJECT", "BUSY_CALLER_ID",
                         "BUSY_END", "END_WAIT"};
  string hexd = "0123456789ABCDEF";

  function automatic logic [127:0] label_bits(input int item);
    logic [127:0] r;
    string s;
    r = {16{8'h20}};
    s = labels[item];
    for (int i = 0; i < s.len(); i++) r[127 - 8*i -: 8] = s[i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = S_INIT; m_item = 0; m_vol = 16; m_phn = '0;
    e_cmd = 0; e_vm = 0; e_ardy = 0; e_txt = 0;
  endtask

  task automatic goto(input int st, input int it);
    m_state = st; m_item = it;
  endtask

  task automatic model_step(input kind_e k, input int code);
    int old_item;
    old_item = m_item;
    e_cmd = 0; e_vm = 0; e_ardy = 0;
    if (k == K_B1 && m_vol < 31) m_vol++;
    if (k == K_B0 && m_vol > 0)  m_vol--;
    if (k == K_B3 && m_state == S_IDLE) e_vm = 1;
    if (k == K_INIT) begin
      goto(S_INIT, 0);
    end else if (k == K_EVT) begin
      if (code != m_prev_inc) begin
        m_prev_inc = code;
        if (code == 5 && m_state == S_IDLE) goto(S_INC, 6);
        else if (code == 6 && m_state >= S_OUT) goto(S_IDLE, 1);
        else if (code == 1 && m_state == S_OUT) goto(S_BUSY, 9);
      end
    end else begin
      case (m_state)
        S_INIT: if (k == K_ENTER) goto(S_IDLE, 0);
        S_IDLE: begin
          if (k == K_RIGHT && m_item <= 1) m_item = 2;
          else if (k == K_LEFT && (m_item == 2 || m_item == 3)) m_item = 1;
          else if ((k == K_UP || k == K_DOWN) && (m_item == 2 || m_item == 3)) m_item = 5 - m_item;
          else if (k == K_ENTER && m_item == 2) m_item = 4;
          else if (k == K_LEFT && m_item == 4) m_item = 2;
          else if (k == K_ENTER && m_item == 4) begin
            e_ardy = (sw != m_phn);
            m_phn = sw; e_cmd = 1; goto(S_OUT, 5);
          end
        end
        S_OUT: if (k == K_LEFT) begin e_cmd = 4; goto(S_IDLE, 1); end
        S_INC: begin
          if (k == K_DOWN) m_item = 6 + (m_item - 6 + 1) % 3;
          else if (k == K_UP) m_item = 6 + (m_item - 6 + 2) % 3;
          else if (k == K_ENTER && m_item == 7) begin e_cmd = 2; goto(S_BUSY, 9); end
          else if (k == K_ENTER && m_item == 8) begin e_cmd = 3; goto(S_IDLE, 1); end
        end
        S_BUSY: begin
          if (k == K_UP || k == K_DOWN) m_item = 19 - m_item;
          else if (k == K_ENTER && m_item == 10) begin e_cmd = 4; goto(S_END, 11); end
        end
        default: ;
      endcase
    end
    e_txt = (m_item != old_item);
  endtask

  task automatic check_after();
    check("state",      current_state,     m_state[2:0]);
    check("item",       current_menu_item, m_item[5:0]);
    check("command",    command,           e_cmd[2:0]);
    check("done",       done,              e_cmd != 0);
    check("volume",     headphone_volume,  m_vol[4:0]);
    check("phn_num",    phn_num,           m_phn);
    check("dout",       dout,              {8'h00, m_phn});
    check("txt_start",  txt_start,         e_txt);
    check("vm_cmd",     voicemail_command, e_vm);
    check("ascii_rdy",  ascii_out_ready,   e_ardy);
    check("ascii",      ascii_out,         8'(hexd[int'(m_phn[3:0])]));
    check("ready",      ready,             m_state != S_INIT);
    check("vm_status",  voicemail_status,  m_state == S_IDLE);
    check("txt_addr",   txt_addr,          12'(m_item * 16));
    check("string",     string_data,       label_bits(m_item));
    check("inc_addr",   inc_address,       {5'b0, inc});
  endtask

  task automatic check_quiet();
    check("q_state",   current_state,     m_state[2:0]);
    check("q_item",    current_menu_item, m_item[5:0]);
    check("q_command", command,           3'd0);
    check("q_done",    done,              1'b0);
    check("q_txt",     txt_start,         1'b0);
    check("q_vm",      voicemail_command, 1'b0);
    check("q_ardy",    ascii_out_ready,   1'b0);
    check("q_volume",  headphone_volume,  m_vol[4:0]);
  endtask

  task automatic press(input kind_e k, input int code);
    case (k)
      K_ENTER: enter = 1;  K_UP: up = 1;  K_DOWN: down = 1;
      K_LEFT:  left = 1;   K_RIGHT: right = 1;
      K_B3: b3 = 1;  K_B1: b1 = 1;  K_B0: b0 = 1;
      K_EVT: inc = code[2:0];
      K_SW:  sw = code[7:0];
      K_INIT: init = 1;
      default: ;
    endcase
  endtask

  task automatic release_all();
    enter = 0; up = 0; down = 0; left = 0; right = 0;
    b3 = 0; b1 = 0; b0 = 0; init = 0;
  endtask

  task automatic act(input kind_e k, input int code);
    press(k, code);
    @(posedge clk); #1;
    model_step(k, code);
    check_after();
    release_all();
    @(posedge clk); #1;
    check_quiet();
  endtask

  initial begin
    model_reset();
    m_prev_inc = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state",  current_state,     3'd0);
    check("rst_item",   current_menu_item, 6'd0);
    check("rst_volume", headphone_volume,  5'd16);
    check("rst_phn",    phn_num,           8'd0);
    check("rst_cmd",    command,           3'd0);
    check("rst_ready",  ready,             1'b0);
    check("rst_txt",    txt_start,         1'b0);
    check("txt_length", txt_length,        12'd16);
    check("din",        din,               16'd0);
    check("audio",      {audio_in_data, audio_out_data}, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Accept an incoming call, then hang up from the busy menu.
    act(K_ENTER, 0);
    act(K_RIGHT, 0);
    act(K_EVT, 5);
    act(K_DOWN, 0);
    act(K_EVT, 1);
    act(K_ENTER, 0);
    act(K_DOWN, 0);
    act(K_ENTER, 0);
    act(K_EVT, 6);

    // Dial 4, check a held event code is not re-used, then connect.
    act(K_RIGHT, 0);
    act(K_ENTER, 0);
    act(K_SW, 4);
    act(K_ENTER, 0);
    act(K_EVT, 6);
    act(K_EVT, 1);
    act(K_EVT, 6);

    // Voicemail, volume saturation both ways, menu wraparound, caller hang-up paths.
    act(K_B3, 0);
    for (int i = 0; i < 20; i++) act(K_B1, 0);
    for (int i = 0; i < 35; i++) act(K_B0, 0);
    act(K_EVT, 5);
    act(K_UP, 0);
    act(K_ENTER, 0);
    act(K_INIT, 0);
    act(K_ENTER, 0);

    for (int n = 0; n < 500; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 20) begin
        int pick;
        pick = $urandom_range(0, 4);
        act(K_EVT, (pick == 0) ? 1 : (pick == 1) ? 5 : (pick == 2) ? 6 : int'($urandom_range(0, 7)));
      end else if (r < 25) begin
        act(K_SW, int'($urandom_range(0, 255)));
      end else if (r < 27) begin
        act(K_INIT, 0);
      end else begin
        act(kind_e'($urandom_range(0, 7)), 0);
      end
    end

    // Drive into BUSY and assert reset within the cycle that carries the accept command.
    act(K_INIT, 0);
    act(K_ENTER, 0);
    act(K_EVT, 0);
    act(K_EVT, 5);
    act(K_DOWN, 0);
    enter = 1;
    @(posedge clk); #1;
    model_step(K_ENTER, 0);
    check_after();
    enter = 0;
    #2 reset = 1'b0;
    #1;
    check("arst_state",  current_state,     3'd0);
    check("arst_item",   current_menu_item, 6'd0);
    check("arst_cmd",    command,           3'd0);
    check("arst_done",   done,              1'b0);
    check("arst_volume", headphone_volume,  5'd16);
    check("arst_phn",    phn_num,           8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
